// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES ripple chunks
// with registered inter-chunk carries and a valid/ready handshake that stalls the whole pipe.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES >= 1");
    end

    // x_q holds finished result chunks below the stage boundary and raw A chunks above it;
    // b_q keeps the already-inverted B operand so subtract needs no extra state.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q;
    logic             zero_q;
    logic             advance;

    assign advance  = !vld_q[STAGES-1] | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] x_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] x_nxt;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   sum;

        if (k == 0) begin : g_first
            assign x_in = A;
            assign b_in = B ^ {WIDTH{sub}};
            assign c_in = sub;
            assign v_in = in_valid;
        end else begin : g_next
            assign x_in = x_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = vld_q[k-1];
        end

        assign sum = {1'b0, x_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_in};

        always_comb begin
            x_nxt = x_in;
            x_nxt[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_nxt;
            logic zero_nxt;

            // The top chunk of x_in is still raw A here, so the operand sign bits are at hand.
            assign ovf_nxt  = ~(x_in[WIDTH-1] ^ b_in[WIDTH-1]) & (x_nxt[WIDTH-1] ^ x_in[WIDTH-1]);
            assign zero_nxt = (x_nxt == '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q[k] <= 1'b0;
                    x_q[k]   <= '0;
                    c_q[k]   <= 1'b0;
                    ovf_q    <= 1'b0;
                    zero_q   <= 1'b0;
                end else if (advance) begin
                    vld_q[k] <= v_in;
                    x_q[k]   <= x_nxt;
                    c_q[k]   <= sum[CHUNK];
                    ovf_q    <= ovf_nxt;
                    zero_q   <= zero_nxt;
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q[k] <= 1'b0;
                end else if (advance) begin
                    vld_q[k] <= v_in;
                    x_q[k]   <= x_nxt;
                    b_q[k]   <= b_in;
                    c_q[k]   <= sum[CHUNK];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = x_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner cases, stall/reset scenarios and a
// randomized stream, all compared against an arithmetic reference model and a result queue.
module tb_pipelined_addsub;

    localparam int W = 32;
    localparam int S = 4;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, sub, out_valid, out_ready, carry, overflow, zero;
    logic [W-1:0] a, b, result;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero)
    );

    // Two narrow instances share one input bus and an always-ready consumer.
    logic       sv, ssub, s_ready;
    logic [7:0] sa, sb;
    logic       s2_in_ready, s2_valid, s2_c, s2_v, s2_z;
    logic       s1_in_ready, s1_valid, s1_c, s1_v, s1_z;
    logic [7:0] s2_res, s1_res;

    pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut_w8s2 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(s2_in_ready),
        .A(sa), .B(sb), .sub(ssub), .out_valid(s2_valid), .out_ready(s_ready),
        .result(s2_res), .carry(s2_c), .overflow(s2_v), .zero(s2_z)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_w8s1 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(s1_in_ready),
        .A(sa), .B(sb), .sub(ssub), .out_valid(s1_valid), .out_ready(s_ready),
        .result(s1_res), .carry(s1_c), .overflow(s1_v), .zero(s1_z)
    );

    int   assertCount = 0;
    int   failCount   = 0;
    bit   chkEn       = 0;
    exp_t expq[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular and signed integer arithmetic on the operand values.
    function automatic exp_t refModel(input longint ua, input longint ub, input bit s, input int w);
        exp_t   e;
        longint m, sa_l, sb_l, sres;
        m    = longint'(1) << w;
        sa_l = (ua >= m / 2) ? ua - m : ua;
        sb_l = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            e.res = 64'((ua - ub + m) % m);
            e.c   = (ua >= ub);
            sres  = sa_l - sb_l;
        end else begin
            e.res = 64'((ua + ub) % m);
            e.c   = ((ua + ub) >= m);
            sres  = sa_l + sb_l;
        end
        e.v = (sres >= m / 2) || (sres < -(m / 2));
        e.z = (e.res == 0);
        return e;
    endfunction

    // Compare process: inputs change just after posedge, so at negedge both sides' transfer
    // decisions for the coming edge are visible and stable.
    logic         stallPrev = 1'b0;
    logic [W-1:0] heldRes;
    logic         heldC, heldV, heldZ;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expq.delete();
            stallPrev = 1'b0;
        end else if (chkEn) begin
            checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
            if (stallPrev) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_result", result, heldRes);
                checkOutput("hold_flags", {carry, overflow, zero}, {heldC, heldV, heldZ});
            end
            if (out_valid && expq.size() == 0) begin
                checkOutput("spurious_out_valid", out_valid, 0);
            end else if (out_valid && out_ready) begin
                e = expq.pop_front();
                checkOutput("stream_result", result, e.res);
                checkOutput("stream_carry", carry, e.c);
                checkOutput("stream_overflow", overflow, e.v);
                checkOutput("stream_zero", zero, e.z);
            end
            if (in_valid && in_ready) expq.push_back(refModel(a, b, sub, W));
            stallPrev = out_valid && !out_ready;
            heldRes = result;
            heldC = carry;
            heldV = overflow;
            heldZ = zero;
        end
    end

    task automatic applyStimulus(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ss);
        int n = 0;
        a = aa;
        b = bb;
        sub = ss;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic runOne(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ss, input logic [W-1:0] er, input logic ec,
                          input logic ev, input logic ez);
        int n = 0;
        applyStimulus(aa, bb, ss);
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_latency"}, n, S - 1);
        checkOutput({name, "_result"}, result, er);
        checkOutput({name, "_carry"}, carry, ec);
        checkOutput({name, "_overflow"}, overflow, ev);
        checkOutput({name, "_zero"}, zero, ez);
        @(posedge clk);
        #1;
    endtask

    task automatic runSmall(input string name, input logic [7:0] aa, input logic [7:0] bb,
                            input logic ss, input logic [7:0] er, input logic ec,
                            input logic ev, input logic ez);
        int         lat1 = -1;
        int         lat2 = -1;
        logic [10:0] got1 = '0;
        logic [10:0] got2 = '0;
        sa = aa;
        sb = bb;
        ssub = ss;
        sv = 1'b1;
        @(posedge clk);
        #1;
        sv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s1_valid && lat1 < 0) begin
                lat1 = i;
                got1 = {s1_res, s1_c, s1_v, s1_z};
            end
            if (s2_valid && lat2 < 0) begin
                lat2 = i;
                got2 = {s2_res, s2_c, s2_v, s2_z};
            end
        end
        checkOutput({name, "_s1_latency"}, lat1, 0);
        checkOutput({name, "_s2_latency"}, lat2, 1);
        checkOutput({name, "_s1_out"}, got1, {er, ec, ev, ez});
        checkOutput({name, "_s2_out"}, got2, {er, ec, ev, ez});
        @(posedge clk);
        #1;
    endtask

    task automatic drainCheck(input string name);
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (expq.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, expq.size(), 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t         m;
        logic [W-1:0] opA [8];
        logic [W-1:0] opB [8];
        logic         opS [8];
        int           sent;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        sub = 1'b0;
        sv = 1'b0;
        sa = '0;
        sb = '0;
        ssub = 1'b0;
        s_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chkEn = 1;
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_outputs", {result, carry, overflow, zero}, '0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Pin the model itself on hand-computed values.
        m = refModel(32'hFFFFFFFF, 32'h1, 1'b0, 32);
        checkOutput("model_wrap", {m.res, m.c, m.v, m.z}, {64'h0, 3'b101});
        m = refModel(32'h5, 32'h7, 1'b1, 32);
        checkOutput("model_borrow", {m.res, m.c, m.v, m.z}, {64'hFFFFFFFE, 3'b000});
        m = refModel(8'h80, 8'h01, 1'b1, 8);
        checkOutput("model_w8_ovf", {m.res, m.c, m.v, m.z}, {64'h7F, 3'b110});

        runOne("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        runOne("add_posovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        runOne("add_negovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
        runOne("sub_5m7", 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        runOne("sub_7m5", 32'd7, 32'd5, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
        runOne("sub_equal", 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

        // Eight back-to-back operations with the consumer stalled on cycles 5-7.
        for (int i = 0; i < 8; i++) begin
            opA[i] = $urandom;
            opB[i] = $urandom;
            opS[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            if (sent < 8) begin
                in_valid = 1'b1;
                a = opA[sent];
                b = opB[sent];
                sub = opS[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        checkOutput("stream8_sent", sent, 8);
        drainCheck("stream8_drain");

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_outputs", {result, carry, overflow, zero}, '0);
        checkOutput("midrst_in_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        runOne("post_reset", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);

        // Randomized stream with random backpressure and occasional corner operands.
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0: a = 32'hFFFFFFFF;
                1: a = 32'h80000000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h00000001;
                1: b = a;
                default: b = $urandom;
            endcase
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        drainCheck("random_drain");

        runSmall("w8_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        runSmall("w8_add", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the fixed 32-bit ripple-carry adder. The WIDTH-bit operands are split into STAGES equal chunks. Each chunk is a ripple segment, and the carry between chunks is registered, so throughput is one operation per clock. It adds a subtract mode, overflow and zero flags, and a valid/ready handshake with backpressure, so the ALU can stream operations through it.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥2 and divisible by STAGES (elaboration error otherwise).
STAGES, 4, pipeline depth = number of chunks; CHUNK = WIDTH/STAGES bits per stage; STAGES ≥ 1.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand set on A/B/sub is valid.
in_ready  out  1  block accepts operands this cycle.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
sub  in  1  0: A+B; 1: A−B.
out_valid  out  1  result/flags valid.
out_ready  in  1  consumer accepts the result this cycle.
result  out  WIDTH  sum/difference modulo 2^WIDTH.
carry  out  1  carry-out of the MSB.
overflow  out  1  signed overflow.
zero  out  1  result == 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Arithmetic:
  - sub=0: {carry,result} = A + B + 0.
  - sub=1: {carry,result} = A + ~B + 1. carry=1 means no borrow (A ≥ B unsigned).
  - overflow = (A[MSB] ~^ Beff[MSB]) & (result[MSB] ^ A[MSB]), where Beff = sub ? ~B : B.
  - zero = (result == 0).
- Pipeline:
  - Stage k (0..STAGES−1) computes bits [k*CHUNK +: CHUNK] using the carry registered by stage k−1. Stage 0 uses cin = sub.
  - Upper operand chunks are delay-registered (skewed) until their stage.
  - Completed lower result bits are carried forward, so each operation stays bit-aligned.
  - Every stage has a valid bit. Final-stage registers drive result/carry/overflow/zero/out_valid directly, with no combinational path from A/B to outputs.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance (combinational).
  - A transfer on the input side occurs when in_valid & in_ready. On the output side it occurs when out_valid & out_ready.
  - When advance=1, every stage loads from its predecessor. Stage 0 loads in_valid and the operands; a cycle with no accepted input inserts a bubble (valid=0).
  - When advance=0, all stages hold, including bubbles; there is no bubble compression.
- Latency: an operation accepted at edge t, with no stall, presents out_valid=1 after edge t+STAGES−1, i.e. STAGES register stages. STAGES=1 gives out_valid the cycle after acceptance.
- Ordering and integrity: results emerge in acceptance order. None are dropped or duplicated under any out_ready pattern.
- Output stability: while out_valid=1 and out_ready=0, result/carry/overflow/zero hold constant.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both honoured.
- Reset:
  - At any time, including mid-operation, reset clears all stage valid bits, so out_valid=0 after the reset edge.
  - result, carry, overflow and zero are 0 after reset.
  - All in-flight operations are discarded.
  - in_ready=1 in the first cycle after reset deasserts.
  - Data registers other than the outputs need not be reset.
- Wrap-around: results are modulo 2^WIDTH; the carry beyond the MSB is reported only on carry.

Test Plan:
1. WIDTH=32, STAGES=4; add 0xFFFFFFFF + 0x00000001, out_ready=1 → 4 cycles later result=0x00000000, carry=1, zero=1, overflow=0.
2. Add 0x7FFFFFFF + 0x00000001 → result=0x80000000, carry=0, overflow=1, zero=0. Add 0x80000000 + 0x80000000 → result=0, carry=1, overflow=1, zero=1.
3. Sub 5−7 → 0xFFFFFFFE, carry=0, overflow=0. Sub 7−5 → 0x00000002, carry=1. Sub 0x12345678−0x12345678 → 0, zero=1, carry=1.
4. Stream 8 back-to-back random ops, out_ready=0 for cycles 5–7 → in_ready=0 exactly while out_valid=1 and out_ready=0. Held outputs stay stable. All 8 results match the model, in order.
5. Accept 3 ops, assert rst for one cycle while they are in flight → out_valid=0 and all outputs 0 after the edge. No stale result ever appears. A following op 1+2 yields 3 after 4 cycles.
6. Parameter sweep WIDTH=8, STAGES=2: sub 0x80−0x01 → 0x7F, carry=1, overflow=1. WIDTH=8, STAGES=1: add 0xFF+0xFF → 0xFE, carry=1, latency 1.
